// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and the frame FSM state
// encoding used by the transmitter (and later the receiver).
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate counter.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic             do_push, do_pop;

   assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty_o = (wptr_q == rptr_q);
   assign level_o = wptr_q - rptr_q;
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: pointer reset already discards contents.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a transmit FIFO; frames are sent
// back to back while characters remain queued.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          uart_tx_en,
   input  logic [DATA_BITS-1:0]          uart_tx_data,
   output logic                          tx_full,
   output logic [$clog2(FIFO_DEPTH):0]   tx_level,
   output logic                          tx_overflow,
   output logic                          tx_busy,
   output logic                          uart_txd
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] D_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
       PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
   begin : g_bad_param
      $error("uart_tx_fifo: parameter out of legal range");
   end

   uart_state_e          state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 txd_q, txd_d;
   logic                 ovf_q;
   logic                 pop;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_rdata;
   logic                 bit_end;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (uart_tx_en),
      .wdata_i (uart_tx_data),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (tx_full),
      .empty_o (fifo_empty),
      .level_o (tx_level)
   );

   assign bit_end     = (timer_q == T_LAST);
   assign uart_txd    = txd_q;
   assign tx_overflow = ovf_q;
   assign tx_busy     = (state_q != ST_IDLE) | (tx_level != '0);

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      txd_d   = txd_q;
      pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            txd_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_rdata;
               par_d   = (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
               timer_d = '0;
               state_d = ST_START;
               txd_d   = 1'b0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               timer_d = '0;
               bit_d   = '0;
               state_d = ST_DATA;
               txd_d   = shift_q[0];
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               timer_d = '0;
               if (bit_q == D_LAST) begin
                  bit_d = '0;
                  if (PARITY != PAR_NONE) begin
                     state_d = ST_PARITY;
                     txd_d   = par_q;
                  end else begin
                     state_d = ST_STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
                  txd_d   = shift_q[1];
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               timer_d = '0;
               bit_d   = '0;
               state_d = ST_STOP;
               txd_d   = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               timer_d = '0;
               if (bit_q == S_LAST) begin
                  // Chain straight into the next start bit when data waits.
                  if (!fifo_empty) begin
                     pop     = 1'b1;
                     shift_d = fifo_rdata;
                     par_d   = (PARITY == PAR_ODD) ? ~^fifo_rdata
                                                   : ^fifo_rdata;
                     state_d = ST_START;
                     txd_d   = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                     txd_d   = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         ovf_q   <= uart_tx_en & tx_full;
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter: the next generation of the existing fixed-format `uart_tx`. It adds a configurable frame format (data width, parity, stop bits), a configurable baud divisor and a small transmit FIFO, so the host can queue several characters without polling `tx_busy` between them. It sits between a host write port and the serial line and is frame-compatible with `uart_rx` when configured 8N1.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 2.
- `DATA_BITS`, 8: payload width; legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `uart_tx_en` in 1: push strobe; each high cycle is one push request.
- `uart_tx_data` in DATA_BITS: character sampled when a push is accepted.
- `tx_full` out 1: FIFO holds FIFO_DEPTH entries.
- `tx_level` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `tx_overflow` out 1: one-cycle pulse when a push is rejected.
- `tx_busy` out 1: high while a frame is in progress or the FIFO is non-empty.
- `uart_txd` out 1: serial line; idles high.

## Operation
- Push: accepted iff `uart_tx_en`=1 and registered `tx_full`=0 at the edge. A push while full is dropped, pulses `tx_overflow` the next cycle, and leaves the FIFO unchanged. This holds even when a pop occurs at the same edge.
- Push and pop at the same edge with a non-full FIFO: both happen, and `tx_level` is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `uart_txd`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `uart_txd`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send DATA_BITS bits, LSB first, each CLKS_PER_BIT cycles. Afterwards go to PARITY if PARITY≠0, else STOP.
  - PARITY: even sends ^data; odd sends ~^data. One bit period, then STOP.
  - STOP: `uart_txd`=1 for STOP_BITS×CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap; else go to IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1 and is sized $clog2(CLKS_PER_BIT). The bit index counts 0..DATA_BITS-1.
- FIFO read/write pointers wrap modulo FIFO_DEPTH, with one extra bit to distinguish full from empty.
- `tx_busy` = (state≠IDLE) | (`tx_level`≠0).
- Parameters outside their legal range are a compile-time error (generate-time check).

## Timing
- Reset values: `uart_txd`=1, `tx_busy`=0, `tx_full`=0, `tx_level`=0, `tx_overflow`=0. FSM in IDLE, FIFO empty.
- Reset asserted mid-frame: `uart_txd` goes high immediately (asynchronously). The frame is abandoned and FIFO contents are discarded.
- `uart_txd` is a register output, so the line is glitch-free.
- Latency: push at edge N into an empty, idle block → level=1 after N, pop and start bit at edge N+1. `uart_txd` is low from N+1 to N+1+CLKS_PER_BIT.
- Frame length = CLKS_PER_BIT×(1+DATA_BITS+(PARITY≠0)+STOP_BITS) cycles.
- `tx_busy` falls on the same edge the FSM enters IDLE with an empty FIFO.
- `tx_level`, `tx_full` and `tx_overflow` update at the edge after the event.

## Structure
- Shared package `uart_pkg`:
  - parity encodings PAR_NONE/PAR_EVEN/PAR_ODD;
  - FSM state encoding, also reused by the future parametrised `uart_rx`.
- One sub-module: `uart_sync_fifo` (parameters WIDTH, DEPTH), a synchronous FIFO with push/pop/full/empty/level and the same asynchronous reset.
- The FSM, bit timer and shift register live in the top module.

## Test plan
- 8N1 framing: CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1; push 0x11 once.
  → `uart_txd` = 0, 1,0,0,0,1,0,0,0, 1, each held 4 cycles (40 cycles total).
  → `tx_busy` is high for exactly 41 cycles, counted from the push edge.
- Parity: same settings with PARITY=1, push 0x11 → parity bit 0. With PARITY=2 → parity bit 1.
- Narrow frame: DATA_BITS=7, push 0x55 → data bits 1,0,1,0,1,0,1.
- Two stop bits: STOP_BITS=2 → line high for 8 cycles after the data bits.
- Back-to-back and overflow: FIFO_DEPTH=4; push 0xA1, then during its start bit push 0xB2, 0xC3, 0xD4, 0xE5, 0xF6.
  → first four are accepted; `tx_full`=1 and `tx_level`=4.
  → 0xF6 is rejected with a one-cycle `tx_overflow` pulse.
  → five frames go out contiguously with no idle cycle between stop and start bits.
- Reset mid-frame: assert `rst` during the data bits of 0x3C with 2 characters queued.
  → `uart_txd`=1 immediately; `tx_level`=0 and `tx_busy`=0.
  → after release, the line stays idle until a new push.
